// File: rtl/spi_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the TX arbiter and the master TX FIFO push port.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface spi_tx_arbiter_if #(
  parameter int NumReq = 4
);
  logic [NumReq-1:0]   req_valid_i;
  logic [8*NumReq-1:0] req_data_i;
  logic [NumReq-1:0]   req_last_i;
  logic [NumReq-1:0]   req_ready_o;
  logic                tx_valid_o;
  logic [7:0]          tx_data_o;
  logic                tx_last_o;
  logic                tx_ready_i;
  logic [NumReq-1:0]   grant_o;
  logic                busy_o;
  logic                timeout_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o, tx_last_o, grant_o, busy_o, timeout_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o, tx_last_o, grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the SPI master TX FIFO push port between NumReq byte streams.
// An owner keeps the path until its last byte or an idle timeout; a fixed gap separates frames.
module spi_tx_arbiter #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 256,
  parameter int GapCycles     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_tx_arbiter_if.master bus
);

  if (NumReq < 2 || NumReq > 8) begin : g_bad_num_req
    $error("spi_tx_arbiter: NumReq must be within 2..8");
  end

  localparam int          PtrW     = $clog2(NumReq);
  localparam logic [15:0] IdleLast = 16'(TimeoutCycles - 1);
  localparam logic [3:0]  GapLast  = 4'(GapCycles - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_GAP} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   idx_q, idx_d;
  logic [PtrW-1:0]   win;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [15:0]       idle_cnt_q, idle_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              timeout_q, timeout_d;
  logic              owner_valid, owner_last, xfer;

  assign owner_valid = bus.req_valid_i[idx_q];
  assign owner_last  = bus.req_last_i[idx_q];
  assign xfer        = (state_q == ST_STREAM) && owner_valid && bus.tx_ready_i;

  // Scanning from the highest offset down lets the smallest offset from the pointer win.
  always_comb begin
    int cand;
    cand = 0;
    win  = ptr_q;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % NumReq;
      if (bus.req_valid_i[cand]) win = PtrW'(cand);
    end
  end

  always_comb begin
    bus.tx_valid_o  = 1'b0;
    bus.tx_data_o   = '0;
    bus.tx_last_o   = 1'b0;
    bus.req_ready_o = '0;
    if (state_q == ST_STREAM) begin
      bus.tx_valid_o          = owner_valid;
      bus.tx_data_o           = bus.req_data_i[8*int'(idx_q) +: 8];
      bus.tx_last_o           = owner_last;
      bus.req_ready_o[idx_q]  = bus.tx_ready_i;
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path through the case infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    idle_cnt_d = idle_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid_i) begin
          state_d       = ST_STREAM;
          idx_d         = win;
          grant_d       = '0;
          grant_d[win]  = 1'b1;
          ptr_d         = (win == PtrW'(NumReq - 1)) ? '0 : win + 1'b1;
          idle_cnt_d    = '0;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (owner_last) begin
            state_d   = ST_GAP;
            grant_d   = '0;
            gap_cnt_d = '0;
          end
        end else if (!owner_valid) begin
          // A stalled-by-backpressure owner never reaches this branch, so only true idleness counts.
          if (idle_cnt_q == IdleLast) begin
            timeout_d  = 1'b1;
            state_d    = ST_GAP;
            grant_d    = '0;
            gap_cnt_d  = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      grant_q    <= '0;
      idle_cnt_q <= '0;
      gap_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      grant_q    <= grant_d;
      idle_cnt_q <= idle_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = (state_q == ST_STREAM);
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: directed scenarios plus random traffic, every cycle
// compared against a behavioural model built from owner/gap/idle bookkeeping in plain integers.
module tb_spi_tx_arbiter;
  localparam int N = 4;
  localparam int T = 256;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_tx_arbiter_if #(.NumReq(N)) bus ();
  spi_tx_arbiter #(.NumReq(N), .TimeoutCycles(T), .GapCycles(G)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-requester byte sources: {last, byte} entries consumed on accepted transfers.
  logic [8:0] sbuf [N][64];
  int         head [N];
  int         tail [N];
  bit         en   [N];
  int         vprob = 100;
  int         rprob = 100;

  // Reference model state.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_idle  = 0;
  int m_gap   = 0;
  bit m_tmo   = 1'b0;
  bit m_xfer  = 1'b0;
  int m_xreq  = -1;

  // Observations taken from the DUT.
  int             tmo_seen = 0;
  int             tmo_cyc  = -1;
  int             gcnt [N];
  int             grant_log[$];
  logic [7:0]     xlog[$];
  logic [N-1:0]   prev_grant = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input bit l);
    if (head[r] == tail[r]) begin
      head[r] = 0;
      tail[r] = 0;
    end
    if (tail[r] < 64) begin
      sbuf[r][tail[r]] = {l, b};
      tail[r]++;
    end
  endtask

  task automatic frame(input int r, input int len);
    for (int k = 0; k < len; k++) push(r, 8'($urandom), k == len - 1);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_idle  = 0;
    m_gap   = 0;
    m_tmo   = 1'b0;
    m_xfer  = 1'b0;
    m_xreq  = -1;
  endtask

  task automatic tick();
    logic [N-1:0]   v, l, eg, er;
    logic [8*N-1:0] d;
    logic [8:0]     e;
    logic           rdy, ev, el;
    logic [7:0]     ed;
    int             o;
    for (int i = 0; i < N; i++) begin
      e = (head[i] < tail[i]) ? sbuf[i][head[i]] : 9'h0;
      v[i] = (head[i] < tail[i]) && en[i] && ($urandom_range(0, 99) < vprob);
      d[8*i +: 8] = e[7:0];
      l[i] = e[8];
    end
    rdy = ($urandom_range(0, 99) < rprob);
    bus.req_valid_i = v;
    bus.req_data_i  = d;
    bus.req_last_i  = l;
    bus.tx_ready_i  = rdy;
    if (rst) model_reset();
    #2;
    o  = m_owner;
    eg = '0;
    er = '0;
    ev = 1'b0;
    ed = 8'h00;
    el = 1'b0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      er[o] = rdy;
      ev    = v[o];
      ed    = d[8*o +: 8];
      el    = l[o];
    end
    check("grant",     32'(bus.grant_o),     32'(eg));
    check("busy",      32'(bus.busy_o),      32'(o >= 0));
    check("timeout",   32'(bus.timeout_o),   32'(m_tmo));
    check("tx_valid",  32'(bus.tx_valid_o),  32'(ev));
    check("tx_data",   32'(bus.tx_data_o),   32'(ed));
    check("tx_last",   32'(bus.tx_last_o),   32'(el));
    check("req_ready", 32'(bus.req_ready_o), 32'(er));
    if (bus.timeout_o) begin
      tmo_seen++;
      tmo_cyc = cyc;
    end
    if (bus.tx_valid_o && bus.tx_ready_i) xlog.push_back(bus.tx_data_o);
    for (int i = 0; i < N; i++) begin
      if (bus.grant_o[i]) gcnt[i]++;
      if (bus.grant_o[i] && prev_grant == '0) grant_log.push_back(i);
    end
    prev_grant = bus.grant_o;
    if (!rst) begin
      m_xfer = 1'b0;
      m_tmo  = 1'b0;
      if (m_owner >= 0) begin
        if (v[o] && rdy) begin
          m_xfer = 1'b1;
          m_xreq = o;
          m_idle = 0;
          head[o]++;
          if (l[o]) begin
            m_owner = -1;
            m_gap   = G;
          end
        end else if (!v[o]) begin
          m_idle++;
          if (m_idle == T) begin
            m_tmo   = 1'b1;
            m_owner = -1;
            m_gap   = G;
            m_idle  = 0;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && v[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_idle  = 0;
          end
        end
        if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(m_owner < 0 && m_gap == 0) && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_idle_bound"}, 32'(n < 600), 32'd1);
  endtask

  task automatic wait_pops(input string tag, input int r, input int target);
    int n;
    n = 0;
    while (head[r] < target && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_pop_bound"}, 32'(n < 600), 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] bp_bytes [4];
    logic [7:0] b2;
    int         k_cyc;
    int         xs;
    bit         injected;

    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      en[i]   = 1'b1;
      gcnt[i] = 0;
    end

    // Reset state, then a single three-byte frame from requester 0.
    do_reset(2);
    push(0, 8'hA5, 1'b0);
    push(0, 8'h5A, 1'b0);
    push(0, 8'h3C, 1'b1);
    xlog.delete();
    ticks(10);
    check("single_grant_cycles", 32'(gcnt[0]), 32'd3);
    check("single_nbytes", 32'(xlog.size()), 32'd3);
    if (xlog.size() == 3) begin
      check("single_b0", 32'(xlog[0]), 32'hA5);
      check("single_b1", 32'(xlog[1]), 32'h5A);
      check("single_b2", 32'(xlog[2]), 32'h3C);
    end

    // Round robin from a fresh pointer; requests 1 and 3 arrive while 2 owns the path.
    do_reset(2);
    frame(1, 2);
    frame(2, 2);
    grant_log.delete();
    injected = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (m_owner == 2 && !injected) begin
        frame(1, 2);
        frame(3, 2);
        injected = 1'b1;
      end
      tick();
    end
    check("rr_grants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      check("rr_first",  32'(grant_log[0]), 32'd1);
      check("rr_second", 32'(grant_log[1]), 32'd2);
      check("rr_third",  32'(grant_log[2]), 32'd3);
      check("rr_fourth", 32'(grant_log[3]), 32'd1);
    end

    // Backpressure longer than the timeout must not release the owner.
    wait_idle("bp");
    for (int k = 0; k < 4; k++) begin
      bp_bytes[k] = 8'($urandom);
      push(0, bp_bytes[k], k == 3);
    end
    xlog.delete();
    tmo_seen = 0;
    wait_pops("bp", 0, 2);
    rprob = 0;
    ticks(300);
    rprob = 100;
    ticks(8);
    check("bp_no_timeout", 32'(tmo_seen), 32'd0);
    check("bp_nbytes", 32'(xlog.size()), 32'd4);
    if (xlog.size() == 4) begin
      for (int k = 0; k < 4; k++) check("bp_byte", 32'(xlog[k]), 32'(bp_bytes[k]));
    end

    // Timeout: requester 3 goes silent mid-frame while requester 0 waits.
    wait_idle("tmo");
    push(3, 8'h77, 1'b0);
    wait_pops("tmo", 3, 1);
    frame(0, 3);
    k_cyc    = cyc;
    tmo_seen = 0;
    tmo_cyc  = -1;
    for (int n = 0; n < 300 && tmo_seen == 0; n++) tick();
    check("tmo_pulses", 32'(tmo_seen), 32'd1);
    check("tmo_latency", 32'(tmo_cyc - k_cyc), 32'(T));
    grant_log.delete();
    ticks(10);
    check("tmo_next_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

    // Last byte arrives in the very cycle the idle count would expire.
    wait_idle("lvt");
    push(1, 8'h11, 1'b0);
    wait_pops("lvt", 1, 1);
    tmo_seen = 0;
    ticks(T - 1);
    b2 = 8'($urandom);
    push(1, b2, 1'b1);
    xs = xlog.size();
    ticks(6);
    check("lvt_no_timeout", 32'(tmo_seen), 32'd0);
    check("lvt_xfer", 32'(xlog.size() - xs), 32'd1);
    if (xlog.size() > 0) check("lvt_byte", 32'(xlog[$]), 32'(b2));

    // Reset during byte 2 of a 4-byte frame, then pointer must be back at 0.
    wait_idle("rst");
    frame(1, 4);
    wait_pops("rst", 1, head[1] + 1);
    rst = 1'b1;
    tick();
    check("rst_grant_now", 32'(bus.grant_o), 32'd0);
    head[1] = tail[1];
    tick();
    rst = 1'b0;
    frame(0, 2);
    frame(2, 2);
    grant_log.delete();
    ticks(10);
    check("rst_winner", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

    // Random traffic with stalls and backpressure.
    vprob = 85;
    rprob = 75;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (head[i] == tail[i] && $urandom_range(0, 9) == 0) frame(i, int'($urandom_range(1, 6)));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
